inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Circular FIFO of FETCH_PACKETs sitting between the fetch stage and the N decoders.
- Accepts up to N fetched packets per cycle and presents the oldest up to N packets, in program order, to the decoders.
- Dispatch reports how many it consumed.
- Flushed wholesale on branch mispredict recovery.

Parameters:
- DEPTH, 8, number of entries; power of two, DEPTH >= N.
- N, 3, superscalar width: max packets enqueued or dequeued per cycle.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_packets  input  N x FETCH_PACKET  packets from fetch; slot 0 is oldest.
- num_fetched  input  $clog2(N+1)  number of valid leading slots in fetch_packets.
- num_dispatched  input  $clog2(N+1)  number of output slots consumed by dispatch this cycle.
- flush  input  1  mispredict recovery; discard all contents.
- inst_buffer_out  output  N x FETCH_PACKET  oldest entries; slot 0 is the head.
- out_count  output  $clog2(N+1)  number of valid leading slots in inst_buffer_out, = min(count, N).
- free_slots  output  $clog2(DEPTH+1)  DEPTH - count, from registered state.

Behaviour:
- State: head, tail (each $clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH+1) bits), entry array.
- Reset (async, active-high): head=0, tail=0, count=0. Outputs then read out_count=0, free_slots=DEPTH, inst_buffer_out all zero. The entry array is not reset. Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Outputs are combinational from registered state only; there is no input-to-output path (see the Optional Feature for the exception).
  - inst_buffer_out[i] = entry[(head+i) mod DEPTH].
  - Slots i >= out_count are driven to zero.
- Enqueue: on the rising edge, write fetch_packets[0..num_fetched-1] to tail..tail+num_fetched-1 (mod DEPTH), then tail += num_fetched. Enqueue-to-output latency is 1 cycle.
- Dequeue: on the same edge, head += num_dispatched.
- count_next = count + num_fetched - num_dispatched.
- Handshake contract:
  - Fetch must hold num_fetched <= min(free_slots, N). free_slots does not credit same-cycle dequeues, so it is conservative.
  - Dispatch must hold num_dispatched <= out_count.
  - Violations are clamped: the effective enqueue is min(num_fetched, free_slots) and the effective dequeue is min(num_dispatched, out_count). Excess packets are dropped and no state is corrupted.
- Simultaneous enqueue and dequeue at full or empty is legal, subject to the clamps above.
  - Full, dequeue 2 and enqueue 0: count = DEPTH-2.
  - Empty, enqueue 3 and dequeue 0: count = 3.
- Flush:
  - On the edge: head=0, tail=0, count=0. Same-cycle num_fetched and num_dispatched are ignored; flush has priority.
  - Next cycle: out_count=0, free_slots=DEPTH.
- Wrap-around: writes and reads that straddle index DEPTH-1 continue at index 0 within a single cycle.
- No state machine beyond the pointers. count is the sole source of full/empty: full when count==DEPTH, empty when count==0.

Optional Feature:
- Macro INST_BUFFER_BYPASS_EN.
- Defined:
  - When count < N, inst_buffer_out slots count..N-1 are filled combinationally from fetch_packets[0..], and out_count = min(count + num_fetched, N).
  - Bypassed packets consumed in the same cycle are not written into the array.
  - Effective tail advance = num_fetched - max(0, num_dispatched - count).
  - Net latency is 0 cycles when the buffer is empty.
- Undefined: behaviour exactly as above, with 1-cycle latency and no input-to-output combinational path.

Decomposition:
- sys_defs.svh: add IB_IDX (logic [$clog2(DEPTH)-1:0]), IB_CNT, and `INST_BUFFER_SZ (default 8). FETCH_PACKET is already defined there and is reused unchanged.
- No sub-module is natural: the pointer/count logic and the read mux are small, so the block stays a single module.

Test Plan:
- Reset then idle -> out_count=0, free_slots=8, inst_buffer_out all zero.
- Enqueue 3 packets with PC=0x0/0x4/0x8, dispatch 0 -> next cycle out_count=3, out[0].PC=0x0, out[2].PC=0x8, free_slots=5.
- Fill to 8, then enqueue 3 and dispatch 2 in one cycle -> enqueue clamped to 0, count=6, head advanced by 2, no PC overwritten.
- Wrap: head=6, count=2 (PCs 0x18/0x1C), enqueue 3 (0x20/0x24/0x28) -> entries land at 0, 1, 2; after dispatching 2, out[0].PC=0x20, out_count=3.
- flush asserted while count=5 with enqueue 3 and dispatch 2 -> next cycle count=0, free_slots=8, out_count=0.
- Assert reset asynchronously mid-cycle with count=4 -> out_count=0 before the next clock edge. With INST_BUFFER_BYPASS_EN defined: empty buffer, enqueue 2, dispatch 2 -> same-cycle out_count=2 and count stays 0.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer: the fetch packet layout and buffer index/count types.
// Default depth comes from `INST_BUFFER_SZ.
`ifndef INST_BUFFER_SZ
`define INST_BUFFER_SZ 8
`endif

package inst_buffer_pkg;

  localparam int IB_DEPTH = `INST_BUFFER_SZ;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } FETCH_PACKET;

  typedef logic [$clog2(IB_DEPTH)-1:0]   IB_IDX;
  typedef logic [$clog2(IB_DEPTH+1)-1:0] IB_CNT;

endpackage

// File: rtl/inst_buffer.sv
// Circular FIFO of fetch packets between fetch and the N decoders; flushed on mispredict.
// Optional same-cycle fetch-to-decode bypass is enabled by defining INST_BUFFER_BYPASS_EN.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = `INST_BUFFER_SZ,
  parameter int N     = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  FETCH_PACKET [N-1:0]          fetch_packets,
  input  logic [$clog2(N+1)-1:0]       num_fetched,
  input  logic [$clog2(N+1)-1:0]       num_dispatched,
  input  logic                         flush,
  output FETCH_PACKET [N-1:0]          inst_buffer_out,
  output logic [$clog2(N+1)-1:0]       out_count,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots
);

  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [NW-1:0] cnt_t;

  function automatic cnt_t cnt_min(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

  idx_t        head_q, head_d;
  idx_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  FETCH_PACKET mem_q [DEPTH];

  cnt_t        fetch_w, free_w, enq_w, deq_w, byp_w;
  cnt_t        wr_num_w, rd_adv_w, out_cnt_w;
  FETCH_PACKET [N-1:0] wdata;

  always_comb begin
    free_w  = cnt_t'(DEPTH) - count_q;
    fetch_w = cnt_min(cnt_t'(num_fetched), cnt_t'(N));
    enq_w   = cnt_min(fetch_w, free_w);
`ifdef INST_BUFFER_BYPASS_EN
    out_cnt_w = cnt_min(count_q + enq_w, cnt_t'(N));
`else
    out_cnt_w = cnt_min(count_q, cnt_t'(N));
`endif
    deq_w = cnt_min(cnt_t'(num_dispatched), out_cnt_w);
`ifdef INST_BUFFER_BYPASS_EN
    // Dequeues beyond the stored entries consume bypassed packets, which never touch the array.
    byp_w = (deq_w > count_q) ? deq_w - count_q : '0;
`else
    byp_w = '0;
`endif
    wr_num_w = enq_w - byp_w;
    rd_adv_w = deq_w - byp_w;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + idx_t'(rd_adv_w);
      tail_d  = tail_q + idx_t'(wr_num_w);
      count_d = count_q + enq_w - deq_w;
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (cnt_t'(j) == cnt_t'(i) + byp_w) wdata[i] = fetch_packets[j];
      end
    end
  end

  always_comb begin
    inst_buffer_out = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_t'(i) < count_q) begin
        inst_buffer_out[i] = mem_q[head_q + idx_t'(i)];
      end
`ifdef INST_BUFFER_BYPASS_EN
      else if (cnt_t'(i) < out_cnt_w) begin
        for (int j = 0; j < N; j++) begin
          if (count_q + cnt_t'(j) == cnt_t'(i)) inst_buffer_out[i] = fetch_packets[j];
        end
      end
`endif
    end
  end

  assign out_count  = CW'(out_cnt_w);
  assign free_slots = free_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; only slots below count are ever presented.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!flush && !reset && cnt_t'(i) < wr_num_w) begin
        mem_q[tail_q + idx_t'(i)] <= wdata[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=8, N=3).
// Covers reset, enqueue/dequeue, full clamp, wrap, flush, over-dispatch and async reset.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 8;

  logic                 clock;
  logic                 reset;
  FETCH_PACKET [N-1:0]  fetch_packets;
  logic [1:0]           num_fetched;
  logic [1:0]           num_dispatched;
  logic                 flush;
  FETCH_PACKET [N-1:0]  inst_buffer_out;
  logic [1:0]           out_count;
  logic [3:0]           free_slots;

  int n_cmp = 0;
  int n_bad = 0;

  inst_buffer #(.DEPTH(DEPTH), .N(N)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_packets   (fetch_packets),
    .num_fetched     (num_fetched),
    .num_dispatched  (num_dispatched),
    .flush           (flush),
    .inst_buffer_out (inst_buffer_out),
    .out_count       (out_count),
    .free_slots      (free_slots)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic FETCH_PACKET mk(input logic [31:0] pc);
    FETCH_PACKET p;
    p.valid = 1'b1;
    p.inst  = pc ^ 32'h1300_0013;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    num_fetched    = '0;
    num_dispatched = '0;
    flush          = 1'b0;
    fetch_packets  = '0;
  endtask

  task automatic enq(input logic [1:0] n, input logic [31:0] pc0, input logic [1:0] deq);
    fetch_packets[0] = mk(pc0);
    fetch_packets[1] = mk(pc0 + 32'd4);
    fetch_packets[2] = mk(pc0 + 32'd8);
    num_fetched      = n;
    num_dispatched   = deq;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    num_fetched    = '0;
    num_dispatched = '0;
    fetch_packets  = '0;
    #12 reset = 1'b0;
    tick();

    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_free", 32'(free_slots), 32'd8);
    check_eq("rst_out_zero", 32'(|inst_buffer_out), 32'd0);

    enq(2'd3, 32'h0, 2'd0);
    check_eq("enq3_out_count", 32'(out_count), 32'd3);
    check_eq("enq3_pc0", inst_buffer_out[0].PC, 32'h0);
    check_eq("enq3_pc1", inst_buffer_out[1].PC, 32'h4);
    check_eq("enq3_pc2", inst_buffer_out[2].PC, 32'h8);
    check_eq("enq3_inst0", inst_buffer_out[0].inst, 32'h1300_0013);
    check_eq("enq3_free", 32'(free_slots), 32'd5);

    enq(2'd3, 32'hC, 2'd0);
    enq(2'd2, 32'h18, 2'd0);
    check_eq("full_free", 32'(free_slots), 32'd0);
    check_eq("full_out_count", 32'(out_count), 32'd3);

    enq(2'd3, 32'h100, 2'd2);
    check_eq("clamp_free", 32'(free_slots), 32'd2);
    check_eq("clamp_pc0", inst_buffer_out[0].PC, 32'h8);
    check_eq("clamp_pc2", inst_buffer_out[2].PC, 32'h10);

    enq(2'd0, 32'h0, 2'd3);
    enq(2'd0, 32'h0, 2'd1);
    check_eq("pre_wrap_count", 32'(out_count), 32'd2);
    check_eq("pre_wrap_pc0", inst_buffer_out[0].PC, 32'h18);
    check_eq("pre_wrap_pc1", inst_buffer_out[1].PC, 32'h1C);
    check_eq("pre_wrap_slot2_zero", inst_buffer_out[2].PC, 32'h0);

    enq(2'd3, 32'h20, 2'd0);
    check_eq("wrap_out_count", 32'(out_count), 32'd3);
    check_eq("wrap_pc2", inst_buffer_out[2].PC, 32'h20);
    check_eq("wrap_free", 32'(free_slots), 32'd3);

    enq(2'd0, 32'h0, 2'd2);
    check_eq("wrap_deq_pc0", inst_buffer_out[0].PC, 32'h20);
    check_eq("wrap_deq_pc2", inst_buffer_out[2].PC, 32'h28);
    check_eq("wrap_deq_count", 32'(out_count), 32'd3);
    check_eq("wrap_deq_free", 32'(free_slots), 32'd5);

    enq(2'd2, 32'h2C, 2'd0);
    check_eq("pre_flush_free", 32'(free_slots), 32'd3);
    flush = 1'b1;
    enq(2'd3, 32'h200, 2'd2);
    check_eq("flush_free", 32'(free_slots), 32'd8);
    check_eq("flush_out_count", 32'(out_count), 32'd0);
    check_eq("flush_out_zero", 32'(|inst_buffer_out), 32'd0);

    enq(2'd1, 32'h40, 2'd0);
    enq(2'd0, 32'h0, 2'd3);
    check_eq("overdeq_free", 32'(free_slots), 32'd8);
    check_eq("overdeq_out_count", 32'(out_count), 32'd0);
    enq(2'd2, 32'h44, 2'd0);
    check_eq("post_flush_pc0", inst_buffer_out[0].PC, 32'h44);
    check_eq("post_flush_pc1", inst_buffer_out[1].PC, 32'h48);

    enq(2'd2, 32'h4C, 2'd0);
    check_eq("pre_rst_free", 32'(free_slots), 32'd4);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_out_count", 32'(out_count), 32'd0);
    check_eq("async_rst_free", 32'(free_slots), 32'd8);
    #1 reset = 1'b0;
    tick();
    check_eq("after_rst_out_count", 32'(out_count), 32'd0);

`ifdef INST_BUFFER_BYPASS_EN
    fetch_packets[0] = mk(32'h300);
    fetch_packets[1] = mk(32'h304);
    num_fetched      = 2'd2;
    num_dispatched   = 2'd2;
    #1;
    check_eq("byp_out_count", 32'(out_count), 32'd2);
    check_eq("byp_pc0", inst_buffer_out[0].PC, 32'h300);
    check_eq("byp_pc1", inst_buffer_out[1].PC, 32'h304);
    tick();
    check_eq("byp_after_count", 32'(out_count), 32'd0);
    check_eq("byp_after_free", 32'(free_slots), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
